// File: rtl/sop_equiv_sweeper.sv
// Exhaustive equivalence sweeper: walks every input vector past a reference and a
// candidate Boolean function and reports mismatch count, first failing vector and pass/fail.
module sop_equiv_sweeper #(
   parameter int N_VARS       = 4,
   parameter int LATENCY      = 0,
   parameter int STOP_ON_FAIL = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              f_ref,
   input  logic              f_dut,
   output logic [N_VARS-1:0] vec_out,
   output logic              vec_valid,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [N_VARS:0]   mismatch_count,
   output logic [N_VARS-1:0] first_fail_vec,
   output logic              first_fail_valid
);

   typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN} state_t;

   localparam logic [N_VARS-1:0] VEC_MAX = {N_VARS{1'b1}};
   localparam logic [N_VARS-1:0] VEC_ONE = {{(N_VARS-1){1'b0}}, 1'b1};
   localparam logic [N_VARS:0]   CNT_MAX = {1'b1, {N_VARS{1'b0}}};
   localparam logic [N_VARS:0]   CNT_ONE = {{N_VARS{1'b0}}, 1'b1};

   state_t            state_q;
   logic [N_VARS-1:0] vec_q;
   logic              vec_valid_q;
   logic              busy_q;
   logic              done_q;
   logic              pass_q;
   logic [N_VARS:0]   mismatch_count_q;
   logic [N_VARS:0]   mismatch_count_d;
   logic [N_VARS-1:0] first_fail_vec_q;
   logic              first_fail_valid_q;

   logic              tag_valid;
   logic [N_VARS-1:0] tag_vec;
   logic              miss;
   logic              last_sample;
   logic              stop;
   logic              finish;

   // The tag travelling alongside the functions' own latency says which vector
   // the responses currently on f_ref/f_dut belong to.
   generate
      if (LATENCY > 0) begin : g_pipe
         logic [N_VARS:0] pipe_q [LATENCY];

         always_ff @(posedge clk) begin
            if (rst || stop) begin
               for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
            end else begin
               pipe_q[0] <= {vec_valid_q, vec_q};
               for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
            end
         end

         assign {tag_valid, tag_vec} = pipe_q[LATENCY-1];
      end else begin : g_comb
         assign {tag_valid, tag_vec} = {vec_valid_q, vec_q};
      end
   endgenerate

   assign miss        = tag_valid && (f_ref != f_dut);
   assign last_sample = tag_valid && (tag_vec == VEC_MAX);
   assign stop        = miss && (STOP_ON_FAIL != 0);
   assign finish      = last_sample || stop;

   assign mismatch_count_d = (miss && (mismatch_count_q != CNT_MAX))
                             ? mismatch_count_q + CNT_ONE : mismatch_count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q            <= S_IDLE;
         vec_q              <= '0;
         vec_valid_q        <= 1'b0;
         busy_q             <= 1'b0;
         done_q             <= 1'b0;
         pass_q             <= 1'b0;
         mismatch_count_q   <= '0;
         first_fail_vec_q   <= '0;
         first_fail_valid_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q            <= S_SWEEP;
                  vec_q              <= '0;
                  vec_valid_q        <= 1'b1;
                  busy_q             <= 1'b1;
                  pass_q             <= 1'b0;
                  mismatch_count_q   <= '0;
                  first_fail_vec_q   <= '0;
                  first_fail_valid_q <= 1'b0;
               end
            end
            default: begin
               mismatch_count_q <= mismatch_count_d;
               if (miss && !first_fail_valid_q) begin
                  first_fail_valid_q <= 1'b1;
                  first_fail_vec_q   <= tag_vec;
               end
               // Pass counts the mismatch sampled on this very edge.
               if (finish) begin
                  state_q     <= S_IDLE;
                  busy_q      <= 1'b0;
                  done_q      <= 1'b1;
                  pass_q      <= (mismatch_count_d == '0);
                  vec_valid_q <= 1'b0;
               end else if (state_q == S_SWEEP) begin
                  if (vec_q == VEC_MAX) begin
                     vec_valid_q <= 1'b0;
                     state_q     <= S_DRAIN;
                  end else begin
                     vec_q <= vec_q + VEC_ONE;
                  end
               end
            end
         endcase
      end
   end

   assign vec_out          = vec_q;
   assign vec_valid        = vec_valid_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign pass             = pass_q;
   assign mismatch_count   = mismatch_count_q;
   assign first_fail_vec   = first_fail_vec_q;
   assign first_fail_valid = first_fail_valid_q;

endmodule

// File: tb/tb_sop_equiv_sweeper.sv
// Directed bench for sop_equiv_sweeper: five instances cover LATENCY 0/1/2,
// STOP_ON_FAIL and N_VARS=1, all driven from one linear stimulus sequence.
module tb_sop_equiv_sweeper;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Instance index: 0 main, 1 stop-on-fail, 2 latency 2, 3 latency 1 mis-set, 4 one variable
   logic [4:0]      start_v;
   logic [4:0]      f_ref_v;
   logic [4:0]      f_dut_v;
   logic [4:0][3:0] vec_v;
   logic [4:0]      vv_v;
   logic [4:0]      busy_v;
   logic [4:0]      done_v;
   logic [4:0]      pass_v;
   logic [4:0][4:0] mc_v;
   logic [4:0][3:0] ffv_v;
   logic [4:0]      ffval_v;

   logic       vec_n1;
   logic [1:0] mc_n1;
   logic       ffv_n1;

   int mode_a;
   int checks = 0;
   int passes = 0;
   int fails  = 0;

   function automatic logic fn_f(input logic [3:0] v);
      return (v[3] & ~v[2]) | (~v[1] & ~v[0]) | (~v[3] & ~v[0]);
   endfunction

   // Stimulus functions for each instance
   always_comb begin
      f_ref_v[0] = fn_f(vec_v[0]);
      f_dut_v[0] = fn_f(vec_v[0]);
      if (mode_a == 1 && vec_v[0] == 4'b0110) f_dut_v[0] = ~fn_f(vec_v[0]);
      if (mode_a == 2) f_dut_v[0] = 1'b0;
      f_ref_v[1] = fn_f(vec_v[1]);
      f_dut_v[1] = 1'b0;
   end

   logic ra1, ra2, rb1, rb2, rc1, rc2, rd1;
   always @(posedge clk) begin
      ra1 <= fn_f(vec_v[2]);  ra2 <= ra1;
      rb1 <= fn_f(vec_v[2]);  rb2 <= rb1;
      rc1 <= fn_f(vec_v[3]);  rc2 <= rc1;
      rd1 <= fn_f(vec_v[3]);
   end
   assign f_ref_v[2] = ra2;
   assign f_dut_v[2] = rb2;
   assign f_ref_v[3] = rc2;
   assign f_dut_v[3] = rd1;
   assign f_ref_v[4] = vec_n1;
   assign f_dut_v[4] = vec_n1;

   assign vec_v[4] = {3'b000, vec_n1};
   assign mc_v[4]  = {3'b000, mc_n1};
   assign ffv_v[4] = {3'b000, ffv_n1};

   sop_equiv_sweeper #(.N_VARS(4), .LATENCY(0), .STOP_ON_FAIL(0)) u_main (
      .clk(clk), .rst(rst), .start(start_v[0]), .f_ref(f_ref_v[0]), .f_dut(f_dut_v[0]),
      .vec_out(vec_v[0]), .vec_valid(vv_v[0]), .busy(busy_v[0]), .done(done_v[0]),
      .pass(pass_v[0]), .mismatch_count(mc_v[0]), .first_fail_vec(ffv_v[0]),
      .first_fail_valid(ffval_v[0]));

   sop_equiv_sweeper #(.N_VARS(4), .LATENCY(0), .STOP_ON_FAIL(1)) u_sof (
      .clk(clk), .rst(rst), .start(start_v[1]), .f_ref(f_ref_v[1]), .f_dut(f_dut_v[1]),
      .vec_out(vec_v[1]), .vec_valid(vv_v[1]), .busy(busy_v[1]), .done(done_v[1]),
      .pass(pass_v[1]), .mismatch_count(mc_v[1]), .first_fail_vec(ffv_v[1]),
      .first_fail_valid(ffval_v[1]));

   sop_equiv_sweeper #(.N_VARS(4), .LATENCY(2), .STOP_ON_FAIL(0)) u_lat2 (
      .clk(clk), .rst(rst), .start(start_v[2]), .f_ref(f_ref_v[2]), .f_dut(f_dut_v[2]),
      .vec_out(vec_v[2]), .vec_valid(vv_v[2]), .busy(busy_v[2]), .done(done_v[2]),
      .pass(pass_v[2]), .mismatch_count(mc_v[2]), .first_fail_vec(ffv_v[2]),
      .first_fail_valid(ffval_v[2]));

   sop_equiv_sweeper #(.N_VARS(4), .LATENCY(1), .STOP_ON_FAIL(0)) u_lat1 (
      .clk(clk), .rst(rst), .start(start_v[3]), .f_ref(f_ref_v[3]), .f_dut(f_dut_v[3]),
      .vec_out(vec_v[3]), .vec_valid(vv_v[3]), .busy(busy_v[3]), .done(done_v[3]),
      .pass(pass_v[3]), .mismatch_count(mc_v[3]), .first_fail_vec(ffv_v[3]),
      .first_fail_valid(ffval_v[3]));

   sop_equiv_sweeper #(.N_VARS(1), .LATENCY(0), .STOP_ON_FAIL(0)) u_n1 (
      .clk(clk), .rst(rst), .start(start_v[4]), .f_ref(f_ref_v[4]), .f_dut(f_dut_v[4]),
      .vec_out(vec_n1), .vec_valid(vv_v[4]), .busy(busy_v[4]), .done(done_v[4]),
      .pass(pass_v[4]), .mismatch_count(mc_n1), .first_fail_vec(ffv_n1),
      .first_fail_valid(ffval_v[4]));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Launch a sweep at edge k and watch 60 cycles; index i is the cycle after edge k+i-1.
   task automatic run_sweep(input int id, input bit repulse, output int busy_cyc,
                            output int done_off, output int done_pulses, output int vec_errs);
      int vcount;
      logic [31:0] vc;
      busy_cyc = 0; done_off = -1; done_pulses = 0; vec_errs = 0; vcount = 0;
      @(negedge clk); start_v[id] = 1'b1;
      @(negedge clk); start_v[id] = 1'b0;
      for (int i = 1; i <= 60; i++) begin
         if (repulse && i == 5) start_v[id] = 1'b1;
         if (repulse && i == 6) start_v[id] = 1'b0;
         if (busy_v[id]) busy_cyc++;
         if (done_v[id]) begin
            done_pulses++;
            if (done_off < 0) done_off = i;
         end
         if (vv_v[id]) begin
            vc = vcount;
            if (vec_v[id] != vc[3:0]) vec_errs++;
            vcount++;
         end
         @(negedge clk);
      end
      $display("sweep inst=%0d busy=%0d done_at=%0d pulses=%0d mc=%0d ffv=%0d ffval=%0d pass=%0d",
               id, busy_cyc, done_off, done_pulses, mc_v[id], ffv_v[id], ffval_v[id], pass_v[id]);
   endtask

   initial begin
      int b, d, p, e;
      rst = 1'b1; start_v = '0; mode_a = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_vec",   vec_v[0], 0);
      check("reset_vv",    vv_v[0], 0);
      check("reset_busy",  busy_v[0], 0);
      check("reset_done",  done_v[0], 0);
      check("reset_pass",  pass_v[0], 0);
      check("reset_mc",    mc_v[0], 0);
      check("reset_ffval", ffval_v[0], 0);

      // Equal functions, full sweep
      run_sweep(0, 1'b0, b, d, p, e);
      check("eq_busy_cycles", b, 16);
      check("eq_done_cycle",  d, 17);
      check("eq_done_pulses", p, 1);
      check("eq_vec_seq",     e, 0);
      check("eq_pass",        pass_v[0], 1);
      check("eq_mc",          mc_v[0], 0);
      check("eq_ffval",       ffval_v[0], 0);

      // Single mismatch at 0110
      mode_a = 1;
      run_sweep(0, 1'b0, b, d, p, e);
      check("inv6_mc",    mc_v[0], 1);
      check("inv6_ffv",   ffv_v[0], 6);
      check("inv6_ffval", ffval_v[0], 1);
      check("inv6_pass",  pass_v[0], 0);
      check("inv6_done",  d, 17);

      // Stuck-at-0 candidate: nine minterms differ
      mode_a = 2;
      run_sweep(0, 1'b0, b, d, p, e);
      check("sa0_mc",   mc_v[0], 9);
      check("sa0_ffv",  ffv_v[0], 0);
      check("sa0_pass", pass_v[0], 0);

      // Stop on first fail
      run_sweep(1, 1'b0, b, d, p, e);
      check("sof_done_cycle", d, 2);
      check("sof_busy",       b, 1);
      check("sof_mc",         mc_v[1], 1);
      check("sof_ffv",        ffv_v[1], 0);
      check("sof_pass",       pass_v[1], 0);
      check("sof_vv_low",     vv_v[1], 0);

      // Two-cycle latency, matched
      run_sweep(2, 1'b0, b, d, p, e);
      check("lat2_busy", b, 18);
      check("lat2_done", d, 19);
      check("lat2_pass", pass_v[2], 1);
      check("lat2_mc",   mc_v[2], 0);

      // Latency mis-set: reference two flops deep, candidate one
      run_sweep(3, 1'b0, b, d, p, e);
      check("lat1_mc",   mc_v[3], 9);
      check("lat1_ffv",  ffv_v[3], 1);
      check("lat1_pass", pass_v[3], 0);

      // Reset in the middle of a sweep
      mode_a = 2;
      @(negedge clk); start_v[0] = 1'b1;
      @(negedge clk); start_v[0] = 1'b0;
      repeat (7) @(negedge clk);
      check("rst_mid_mc", mc_v[0], 4);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_outputs_zero",
            {vec_v[0], vv_v[0], busy_v[0], done_v[0], pass_v[0], mc_v[0], ffv_v[0], ffval_v[0]}, 0);
      p = 0;
      repeat (30) begin
         if (done_v[0]) p++;
         @(negedge clk);
      end
      check("rst_no_done", p, 0);
      mode_a = 0;
      run_sweep(0, 1'b0, b, d, p, e);
      check("post_rst_pass", pass_v[0], 1);
      check("post_rst_busy", b, 16);

      // start re-pulsed while busy
      run_sweep(0, 1'b1, b, d, p, e);
      check("repulse_busy",   b, 16);
      check("repulse_done",   d, 17);
      check("repulse_pulses", p, 1);

      // One-variable sweep
      run_sweep(4, 1'b0, b, d, p, e);
      check("n1_done", d, 3);
      check("n1_busy", b, 2);
      check("n1_vec",  e, 0);
      check("n1_pass", pass_v[4], 1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/sop_equiv_sweeper.md
Name: sop_equiv_sweeper

Overview:
Sequential exhaustive equivalence checker for N-input single-output Boolean functions (gate-level SOP / NAND-only / NOR-only realisations).
- Drives every input vector 0..2^N_VARS-1 onto a shared bus, one per clock.
- Samples a reference response and a candidate response after a fixed pipeline latency.
- Counts mismatches, captures the first failing vector and reports pass/fail through a start/done handshake.
- Sits beside the gate-level implementations as a reusable in-fabric self-check, replacing hand-written vector lists.

Parameters:
N_VARS, 4, number of function inputs (1..16); the sweep covers 2^N_VARS vectors.
LATENCY, 0, clock cycles from vec_out changing to the matching f_ref/f_dut being valid (0..15); 0 means purely combinational DUTs.
STOP_ON_FAIL, 0, 1 = end the sweep at the first mismatch; 0 = complete the full sweep.

Ports:
clk  input  1  rising-edge clock; the only clock.
rst  input  1  synchronous, active-high reset.
start  input  1  request a sweep; sampled only in IDLE.
f_ref  input  1  reference function output for vector vec_out delayed by LATENCY.
f_dut  input  1  candidate function output for the same vector.
vec_out  output  N_VARS  current input vector to both functions; bit N_VARS-1 is the MSB variable (w for N_VARS=4).
vec_valid  output  1  vec_out carries a sweep vector.
busy  output  1  sweep in progress.
done  output  1  one-cycle pulse; sweep finished.
pass  output  1  result of the last completed sweep; 1 = zero mismatches.
mismatch_count  output  N_VARS+1  mismatches in the current or last sweep (saturates at 2^N_VARS, never wraps).
first_fail_vec  output  N_VARS  vector of the first mismatch.
first_fail_valid  output  1  first_fail_vec holds a captured value.

Behaviour:
- Reset (synchronous, active-high, dominates every other input):
  - All outputs go to 0; the FSM goes to IDLE.
  - The tag pipeline is cleared.
  - Reset asserted mid-sweep aborts the sweep with no done pulse.
- FSM states: IDLE, SWEEP, DRAIN.
  - IDLE: start=1 at edge k moves to SWEEP. The same edge sets vec_out=0, vec_valid=1, busy=1 and clears mismatch_count, first_fail_valid, first_fail_vec and pass.
  - SWEEP: vec_out increments by 1 each edge. When the edge would take vec_out past 2^N_VARS-1, vec_valid goes to 0, vec_out holds its last value, and the FSM goes to DRAIN (or straight to IDLE-with-done if LATENCY=0).
  - DRAIN: waits until the last vector's response has been sampled, then returns to IDLE.
- Sample pipeline:
  - A LATENCY-deep shift register carries {vec_valid, vec_out} as a tag.
  - At each edge where the tag emerging from the pipeline is valid (for LATENCY=0, the current vec_valid/vec_out pair), the block compares f_ref against f_dut.
  - On inequality: mismatch_count increments (saturating). If first_fail_valid=0, first_fail_vec is set to the tag vector and first_fail_valid to 1.
- Termination:
  - Normal end is the edge that samples the tag of vector 2^N_VARS-1, which is edge k+2^N_VARS+LATENCY.
  - At that edge: busy goes to 0, done goes to 1 for exactly one cycle, and pass = (final mismatch_count == 0), counting the mismatch sampled at that same edge.
  - busy is high for 2^N_VARS+LATENCY cycles; done follows in the next cycle.
- STOP_ON_FAIL=1: the edge that samples the first mismatch terminates the sweep exactly as above, with pass=0 and mismatch_count=1. vec_valid goes to 0 and the pipeline is flushed. In-flight tags are discarded and never compared.
- start while busy is ignored. start held high in IDLE after done launches a new sweep at the next edge.
- Result outputs (pass, mismatch_count, first_fail_*) hold until the next accepted start or reset.
- f_ref and f_dut are ignored whenever no valid tag is being sampled.

Test Plan:
- N_VARS=4, LATENCY=0; f_ref and f_dut both implement F=wx'+y'z'+w'z'; start pulse at edge k -> vec_out steps 0..15; busy high for 16 cycles; done pulses in cycle k+17; pass=1, mismatch_count=0, first_fail_valid=0.
- Same setup, but f_dut forced inverted only when vec_out=4'b0110 -> mismatch_count=1, first_fail_vec=4'b0110, pass=0.
- f_dut stuck-at-0 against the true F (minterms 0,2,4,6,8,9,10,11,12) -> mismatch_count=9, first_fail_vec=0; then with STOP_ON_FAIL=1 -> done in cycle k+2, mismatch_count=1, first_fail_vec=0.
- LATENCY=2; both functions registered through 2 flops; equal -> busy high for 18 cycles, pass=1. The same bench with LATENCY=1 mis-set -> mismatches reported, proving the sample alignment is checked.
- rst asserted in cycle k+8 of a sweep -> next cycle all outputs 0, no done pulse. A new start then runs a full clean sweep.
- start re-pulsed during busy -> ignored, and the sweep length is unchanged. N_VARS=1 sweep -> 2 vectors, done in cycle k+3.
